// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small TX FIFO and an internal baud
// prescaler. Frames go out LSB first, back-to-back while the FIFO has data.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit.
//
//   state    | meaning
//   S_IDLE   | line high, waiting for a queued byte
//   S_START  | start bit (low) for N cycles
//   S_DATA   | data bits, LSB first, N cycles each
//   S_PARITY | even-parity bit (UART_TX_PARITY_EN builds only)
//   S_STOP   | stop bit (high); last cycle pulses tx_done
module uart_tx #(
    parameter int P_UART_WIDTH = 8,
    parameter int P_BAUD       = 9600,
    parameter int P_SYS_CLK_HZ = 500000000,
    parameter int P_FIFO_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    input  logic [P_UART_WIDTH-1:0] data_in,
    input  logic                    write_en,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    overflow,
    output logic                    busy,
    output logic                    tx_done,
    output logic                    serial_out
);

    localparam int LP_N  = P_SYS_CLK_HZ / P_BAUD;
    localparam int LP_CW = (LP_N > 1) ? $clog2(LP_N) : 1;
    localparam int LP_IW = (P_UART_WIDTH > 1) ? $clog2(P_UART_WIDTH) : 1;
    localparam int LP_AW = $clog2(P_FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} t_state;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} t_state;
`endif

    t_state                  r_state;
    t_state                  w_next;
    logic [LP_CW-1:0]        r_cnt;
    logic [LP_IW-1:0]        r_idx;
    logic [P_UART_WIDTH-1:0] r_shift;
    logic                    r_serial;
    logic [P_UART_WIDTH-1:0] r_mem [P_FIFO_DEPTH];
    logic [LP_AW-1:0]        r_wr_ptr;
    logic [LP_AW-1:0]        r_rd_ptr;
    logic [LP_AW:0]          r_count;
    logic                    r_overflow;
`ifdef UART_TX_PARITY_EN
    logic                    r_parity;
`endif

    logic w_bit_end;
    logic w_last_bit;
    logic w_pop;
    logic w_push;

    assign w_bit_end  = (r_cnt == LP_CW'(LP_N - 1));
    assign w_last_bit = (r_idx == LP_IW'(P_UART_WIDTH - 1));
    assign fifo_full  = (r_count == (LP_AW+1)'(P_FIFO_DEPTH));
    assign fifo_empty = (r_count == '0);
    assign overflow   = r_overflow;
    assign serial_out = r_serial;
    // A pop frees a slot on the same edge, so a write to a full FIFO is kept.
    assign w_push     = write_en && (!fifo_full || w_pop);

    // State register.
    always_ff @(posedge CLK) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!fifo_empty) w_next = S_START;
            S_START:  if (w_bit_end) w_next = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (w_bit_end && w_last_bit) w_next = S_PARITY;
            S_PARITY: if (w_bit_end) w_next = S_STOP;
`else
            S_DATA:   if (w_bit_end && w_last_bit) w_next = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_next = fifo_empty ? S_IDLE : S_START;
            default:  w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs and the FIFO pop strobe.
    always_comb begin
        busy    = (r_state != S_IDLE);
        tx_done = (r_state == S_STOP) && w_bit_end;
        w_pop   = !fifo_empty &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    end

    // Bit timing, shift register and registered TX line.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_serial <= 1'b1;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_parity <= ^r_mem[r_rd_ptr];
`endif
            end
            if (r_state == S_IDLE || w_bit_end) r_cnt <= '0;
            else                                r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (!fifo_empty) r_serial <= 1'b0;
                end
                S_START: if (w_bit_end) begin
                    r_serial <= r_shift[0];
                    r_shift  <= r_shift >> 1;
                    r_idx    <= '0;
                end
                S_DATA: if (w_bit_end) begin
                    if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                        r_serial <= r_parity;
`else
                        r_serial <= 1'b1;
`endif
                    end else begin
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_idx    <= r_idx + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: if (w_bit_end) r_serial <= 1'b1;
`endif
                // Next frame's start bit follows the stop bit with no gap.
                S_STOP: if (w_bit_end) r_serial <= fifo_empty;
                default: r_serial <= 1'b1;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (write_en && !w_push)   r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with N = 10 cycles per bit. The reference model keeps
// the start edge of every accepted byte and derives all outputs from frame
// arithmetic: a byte written at edge w starts at max(w+1, end of previous
// frame) and its FIFO slot is freed at that start edge.
module tb_uart_tx;

    localparam int W     = 8;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD  = 100000;
    localparam int N     = CLK_HZ / BAUD;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif
    localparam int FRAME = NBITS * N;

    logic         CLK = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         write_en = 1'b0;
    logic         fifo_full, fifo_empty, overflow, busy, tx_done, serial_out;

    uart_tx #(
        .P_UART_WIDTH(W),
        .P_BAUD(BAUD),
        .P_SYS_CLK_HZ(CLK_HZ),
        .P_FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .data_in(data_in),
        .write_en(write_en),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .overflow(overflow),
        .busy(busy),
        .tx_done(tx_done),
        .serial_out(serial_out)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;
    int edge_n = 0;

    int           s_q[$];
    logic [W-1:0] d_q[$];
    int           t_free = 0;
    logic         m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int pending(input int e);
        int c = 0;
        for (int i = 0; i < s_q.size(); i++) if (s_q[i] > e) c++;
        return c;
    endfunction

    function automatic logic exp_line(input int e);
        for (int i = 0; i < s_q.size(); i++) begin
            if (s_q[i] <= e && e < s_q[i] + FRAME) begin
                int o = (e - s_q[i]) / N;
                logic [W-1:0] d = d_q[i];
                if (o == 0) return 1'b0;
                if (o <= W) return d[o-1];
`ifdef UART_TX_PARITY_EN
                if (o == W + 1) return ^d;
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int e);
        for (int i = 0; i < s_q.size(); i++)
            if (s_q[i] <= e && e < s_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int e);
        for (int i = 0; i < s_q.size(); i++)
            if (e == s_q[i] + FRAME - 1) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic tick(input logic we, input logic [W-1:0] din, input logic rn);
        int s;
        write_en = we;
        data_in  = we ? din : W'($urandom);
        reset_n  = rn;
        @(posedge CLK);
        edge_n++;
        if (!rn) begin
            s_q.delete();
            d_q.delete();
            t_free = 0;
            m_ovf  = 1'b0;
        end else begin
            while (s_q.size() > 0 && s_q[0] + FRAME < edge_n) begin
                void'(s_q.pop_front());
                void'(d_q.pop_front());
            end
            if (we) begin
                if (pending(edge_n) < DEPTH) begin
                    s = (edge_n + 1 > t_free) ? edge_n + 1 : t_free;
                    s_q.push_back(s);
                    d_q.push_back(din);
                    t_free = s + FRAME;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        #1;
        chk("serial_out", serial_out, exp_line(edge_n));
        chk("busy",       busy,       exp_busy(edge_n));
        chk("tx_done",    tx_done,    exp_done(edge_n));
        chk("fifo_full",  fifo_full,  pending(edge_n) == DEPTH);
        chk("fifo_empty", fifo_empty, pending(edge_n) == 0);
        chk("overflow",   overflow,   m_ovf);
    endtask

    // Send one byte from idle and decode the line by mid-bit sampling.
    task automatic send_and_decode(input logic [W-1:0] b, input string tag);
        int k, s, busy_cnt, done_edge;
        logic [W-1:0] rx;
        logic stop_bit, par_bit;
        rx = '0; stop_bit = 1'b0; par_bit = 1'b0;
        busy_cnt = 0; done_edge = -1;
        tick(1'b1, b, 1'b1);
        k = edge_n;
        s = k + 1;
        for (int j = 0; j < FRAME + 5; j++) begin
            tick(1'b0, '0, 1'b1);
            if (busy) busy_cnt++;
            if (tx_done) done_edge = edge_n;
            for (int i = 0; i < W; i++)
                if (edge_n == s + N*(i+1) + N/2) rx[i] = serial_out;
            if (edge_n == s + N*(W+1) + N/2) par_bit = serial_out;
            if (edge_n == s + N*(NBITS-1) + N/2) stop_bit = serial_out;
        end
        chk({tag, "_rx_byte"}, rx, b);
        chk({tag, "_stop_bit"}, stop_bit, 1'b1);
        chk({tag, "_frame_len"}, busy_cnt, FRAME);
        chk({tag, "_done_edge"}, done_edge, k + FRAME);
`ifdef UART_TX_PARITY_EN
        chk({tag, "_parity"}, par_bit, ^b);
`endif
    endtask

    initial begin
        int k0, n_done, last_done, waited;
        int done_edges[$];

        // Reset
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1);

        // Single bytes with independent line decode
        send_and_decode(8'hA5, "a5");
        send_and_decode(8'h07, "h07");

        // Back-to-back frames
        tick(1'b1, 8'h00, 1'b1);
        k0 = edge_n;
        tick(1'b1, 8'hFF, 1'b1);
        tick(1'b1, 8'h55, 1'b1);
        for (int j = 0; j < 3*FRAME + 10; j++) begin
            tick(1'b0, '0, 1'b1);
            if (tx_done) done_edges.push_back(edge_n);
        end
        chk("b2b_done_count", done_edges.size(), 3);
        if (done_edges.size() == 3) begin
            chk("b2b_first_done", done_edges[0], k0 + FRAME);
            chk("b2b_gap1", done_edges[1] - done_edges[0], FRAME);
            chk("b2b_gap2", done_edges[2] - done_edges[1], FRAME);
        end

        // Fill to full and overflow
        for (int j = 0; j < 6; j++) begin
            tick(1'b1, W'($urandom), 1'b1);
            if (j == 4) chk("ovf_full_after5", fifo_full, 1'b1);
        end
        chk("ovf_set", overflow, 1'b1);
        n_done = 0;
        for (int j = 0; j < 5*FRAME + 20; j++) begin
            tick(1'b0, '0, 1'b1);
            if (tx_done) n_done++;
        end
        chk("ovf_frames", n_done, 5);
        chk("ovf_sticky", overflow, 1'b1);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);

        // Write on the edge a stop bit ends while full
        for (int j = 0; j < 5; j++) tick(1'b1, W'($urandom), 1'b1);
        waited = 0;
        while (!tx_done && waited < 2*FRAME) begin
            tick(1'b0, '0, 1'b1);
            waited++;
        end
        chk("pp_wait_timeout", waited < 2*FRAME, 1'b1);
        tick(1'b1, W'($urandom), 1'b1);
        chk("pp_overflow", overflow, 1'b0);
        chk("pp_full", fifo_full, 1'b1);
        for (int j = 0; j < 5*FRAME + 20; j++) tick(1'b0, '0, 1'b1);

        // Reset during data bit 3
        tick(1'b1, W'($urandom), 1'b1);
        k0 = edge_n;
        tick(1'b1, W'($urandom), 1'b1);
        tick(1'b1, W'($urandom), 1'b1);
        while (edge_n < k0 + 1 + 4*N + 4) tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
        chk("rst_serial", serial_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        n_done = 0;
        for (int j = 0; j < FRAME + 10; j++) begin
            tick(1'b0, '0, 1'b1);
            if (tx_done) n_done++;
        end
        chk("rst_no_done", n_done, 0);

        // Random traffic against the model
        last_done = 0;
        for (int j = 0; j < 1500; j++) begin
            tick($urandom_range(0, 15) == 0, W'($urandom), 1'b1);
            if (tx_done) last_done++;
        end
        for (int j = 0; j < (DEPTH+1)*FRAME + 10; j++) tick(1'b0, '0, 1'b1);
        chk("rand_drained", fifo_empty, 1'b1);
        chk("rand_saw_frames", last_done > 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
